// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the SRAM port arbiter.
// Defines the req_we encoding and the requester-ID width helper.
package sram_arb_pkg;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // ID width, never zero even for a degenerate single-requester build
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester, response and SRAM-side bus of the SRAM port arbiter.
// slave = arbiter side, master = requesters/consumer/SRAM side.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned IDW = idw(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_we;
  logic [N_REQ*AW-1:0]    req_addr;
  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]       req_ready;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  logic [AW-1:0]          sram_addr;
  logic                   sram_ren;
  logic                   sram_wen;
  logic [WIDTH-1:0]       sram_d;
  logic [WIDTH-1:0]       sram_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_q,
    output req_ready, rsp_valid, rsp_id, rsp_data, sram_addr, sram_ren, sram_wen, sram_d
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_q,
    input  req_ready, rsp_valid, rsp_id, rsp_data, sram_addr, sram_ren, sram_wen, sram_d
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = idw(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  int unsigned    cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = 32'(ptr_i) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDW'(cand);
      if (!any_o && eligible_i[cand_idx]) begin
        any_o             = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM between N_REQ requesters,
// with in-order, ID-tagged read responses through a credit-protected FIFO.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned RSP_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned IDW = idw(N_REQ);
  localparam int unsigned PW  = $clog2(RSP_DEPTH);
  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);

  logic [IDW-1:0]   rr_ptr_d, rr_ptr_q;
  logic             inflight_d, inflight_q;
  logic [IDW-1:0]   inflight_id_d, inflight_id_q;
  logic [CW-1:0]    count_d, count_q;
  logic [PW-1:0]    wptr_d, wptr_q, rptr_d, rptr_q;
  logic [IDW-1:0]   fifo_id_d [RSP_DEPTH];
  logic [IDW-1:0]   fifo_id_q [RSP_DEPTH];
  logic [WIDTH-1:0] fifo_data_d [RSP_DEPTH];
  logic [WIDTH-1:0] fifo_data_q [RSP_DEPTH];

  logic             rsp_valid, push, pop, rd_ok;
  logic [N_REQ-1:0] eligible, pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any, grant_vld, grant_we;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outputs are forced quiet during rst even though state clears only at the edge
  assign rsp_valid = (count_q != '0) && !rst;
  assign pop       = rsp_valid && bus.rsp_ready;
  assign push      = inflight_q;

  // Credit counts the read in flight so a full FIFO can never be overrun
  assign rd_ok = (32'(count_q) + 32'(inflight_q) - 32'(pop)) < RSP_DEPTH;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && ((bus.req_we[i] == WR) || rd_ok);
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (pick_onehot),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  assign grant_vld     = pick_any && !rst;
  assign grant_we      = bus.req_we[pick_idx];
  assign bus.req_ready = grant_vld ? pick_onehot : '0;

  always_comb begin
    bus.sram_addr = '0;
    bus.sram_d    = '0;
    bus.sram_ren  = 1'b0;
    bus.sram_wen  = 1'b0;
    if (grant_vld) begin
      bus.sram_addr = bus.req_addr[pick_idx*AW +: AW];
      bus.sram_d    = bus.req_wdata[pick_idx*WIDTH +: WIDTH];
      bus.sram_wen  = (grant_we == WR);
      bus.sram_ren  = (grant_we == RD);
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    inflight_d    = grant_vld && (grant_we == RD);
    inflight_id_d = pick_idx;
    if (grant_vld) begin
      rr_ptr_d = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Read data arrives one cycle after the grant and is captured with its tag
  always_comb begin
    fifo_id_d   = fifo_id_q;
    fifo_data_d = fifo_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_id_d[wptr_q]   = inflight_id_q;
      fifo_data_d[wptr_q] = bus.sram_q;
      wptr_d              = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = fifo_id_q[rptr_q];
  assign bus.rsp_data  = fifo_data_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_id_q   <= fifo_id_d;
    fifo_data_q <= fifo_data_d;
  end

  a_no_ren_wen: assert property (@(posedge clk) disable iff (rst)
    !(bus.sram_ren && bus.sram_wen));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a random
// read/write mix, all read responses checked against a scoreboard queue.
module tb_sram_port_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned D   = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned IDW = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } rsp_t;

  logic clk;
  logic rst;

  sram_port_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

  sram_port_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .DEPTH     (D),
    .RSP_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, write visible next cycle
  logic [W-1:0] sram_mem [D];
  always @(posedge clk) begin
    if (bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_d;
    if (bus.sram_ren) bus.sram_q <= sram_mem[bus.sram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: monitor observes grants, updates the memory model, queues expected reads
  logic [W-1:0]  model [D];
  rsp_t          exp_q [$];
  rsp_t          exp_e;
  logic [AW-1:0] mon_addr;
  int            waits [N];
  bit            fair_mode = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      check_eq("ren_wen_excl", 64'(bus.sram_ren & bus.sram_wen), 64'd0);
      check_eq("strobe_no_grant",
               64'((bus.sram_ren | bus.sram_wen) & (bus.req_ready == '0)), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_addr = bus.req_addr[i*AW +: AW];
          check_eq("sram_addr", 64'(bus.sram_addr), 64'(mon_addr));
          if (bus.req_we[i]) begin
            model[mon_addr] = bus.req_wdata[i*W +: W];
            check_eq("wen_on_write", 64'(bus.sram_wen), 64'd1);
            check_eq("sram_d", 64'(bus.sram_d), 64'(model[mon_addr]));
          end else begin
            check_eq("ren_on_read", 64'(bus.sram_ren), 64'd1);
            exp_q.push_back('{id: IDW'(i), data: model[mon_addr]});
          end
          if (fair_mode) check_eq("wait_bound", 64'(waits[i] < N), 64'd1);
          waits[i] = 0;
        end else if (bus.req_valid[i]) begin
          waits[i]++;
        end else begin
          waits[i] = 0;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check_eq("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check_eq("rsp_id", 64'(bus.rsp_id), 64'(exp_e.id));
          check_eq("rsp_data", 64'(bus.rsp_data), 64'(exp_e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input logic [W-1:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = AW'(addr);
    bus.req_wdata[i*W +: W]   = d;
  endtask

  // Single transaction; holds valid until granted, bounded by a cycle budget
  task automatic issue(input int i, input logic we, input int addr, input logic [W-1:0] d);
    bit got;
    got = 1'b0;
    set_req(i, we, addr, d);
    for (int k = 0; k < 32 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1'b1;
      step();
    end
    bus.req_valid[i] = 1'b0;
    check_eq("issue_done", 64'(got), 64'd1);
  endtask

  task automatic run_random(input int cycles, input bit fair);
    logic [N-1:0] hs;
    fair_mode = fair;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      step();
      if (!fair) bus.rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !bus.req_valid[i]) begin
          if ($urandom_range(9) < 6) set_req(i, 1'($urandom_range(1)), $urandom_range(7), $urandom);
          else bus.req_valid[i] = 1'b0;
        end
      end
    end
    fair_mode = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1);
  end

  int rd_cnt, wr_cnt, n_rsp;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.sram_q    = '0;
    step();
    step();
    @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_ren", 64'(bus.sram_ren), 64'd0);
    check_eq("rst_wen", 64'(bus.sram_wen), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // Write then read-after-write from requester 1
    set_req(1, 1'b1, 5, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("raw_wr_ready", 64'(bus.req_ready), 64'b0010);
    check_eq("raw_wr_wen", 64'(bus.sram_wen), 64'd1);
    check_eq("raw_wr_ren", 64'(bus.sram_ren), 64'd0);
    step();
    bus.req_we[1] = 1'b0;
    @(negedge clk);
    check_eq("raw_rd_ready", 64'(bus.req_ready), 64'b0010);
    check_eq("raw_rd_ren", 64'(bus.sram_ren), 64'd1);
    check_eq("raw_rd_wen", 64'(bus.sram_wen), 64'd0);
    step();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("raw_rsp_early", 64'(bus.rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check_eq("raw_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("raw_rsp_id", 64'(bus.rsp_id), 64'd1);
    check_eq("raw_rsp_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
    step();

    // Preload 0..7 from requester 3, leaving the pointer wrapped to 0
    for (int a = 0; a < 8; a++) issue(3, 1'b1, a, W'(10 + a));

    // All four read at once: grants and responses in round-robin order
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) check_eq("rr_order", 64'(bus.req_ready), 64'(1 << c));
      if (c >= 2) begin
        check_eq("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("rr_rsp_id", 64'(bus.rsp_id), 64'(c - 2));
        check_eq("rr_rsp_data", 64'(bus.rsp_data), 64'(10 + c - 2));
      end
      step();
      if (c < 4) bus.req_valid[c] = 1'b0;
    end
    step();

    // Back-pressure: reads stall at two credits while writes keep flowing
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, 0, '0);
    set_req(2, 1'b1, 9, 32'h1234_5678);
    rd_cnt = 0;
    wr_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_cnt += int'(bus.req_ready[0]);
      wr_cnt += int'(bus.req_ready[2]);
      step();
    end
    @(negedge clk);
    check_eq("bp_rd_stalled", 64'(bus.req_ready[0]), 64'd0);
    check_eq("bp_wr_granted", 64'(bus.req_ready[2]), 64'd1);
    check_eq("bp_rd_count", 64'(rd_cnt), 64'd2);
    check_eq("bp_wr_flow", 64'(wr_cnt >= 4), 64'd1);
    step();
    bus.req_valid[2] = 1'b0;
    bus.rsp_ready    = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("bp_rd_resume", 64'(bus.req_ready[0]), 64'd1);
      n_rsp += int'(bus.rsp_valid);
      step();
      if (c == 0) bus.req_valid[0] = 1'b0;
    end
    check_eq("bp_drain_count", 64'(n_rsp), 64'd3);

    // Reset with one queued response and one read in flight
    bus.rsp_ready = 1'b0;
    issue(0, 1'b0, 1, '0);
    step();
    step();
    set_req(0, 1'b0, 1, '0);
    @(negedge clk);
    check_eq("mr_rd_granted", 64'(bus.req_ready[0]), 64'd1);
    step();
    bus.req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_rsp += int'(bus.rsp_valid);
      step();
    end
    check_eq("mr_no_stale_rsp", 64'(n_rsp), 64'd0);
    set_req(0, 1'b0, 2, '0);
    set_req(3, 1'b0, 3, '0);
    @(negedge clk);
    check_eq("mr_ptr_restart", 64'(bus.req_ready), 64'b0001);
    step();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("mr_next_grant", 64'(bus.req_ready), 64'b1000);
    step();
    bus.req_valid[3] = 1'b0;

    // Lone requester 3 granted at once, pointer wraps to 0
    set_req(3, 1'b0, 4, '0);
    @(negedge clk);
    check_eq("wrap_grant3", 64'(bus.req_ready), 64'b1000);
    step();
    set_req(0, 1'b0, 6, '0);
    @(negedge clk);
    check_eq("wrap_ptr0", 64'(bus.req_ready), 64'b0001);
    step();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("wrap_then3", 64'(bus.req_ready), 64'b1000);
    step();
    bus.req_valid[3] = 1'b0;
    step();

    run_random(5000, 1'b1);
    run_random(5000, 1'b0);

    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single_port_sram between N_REQ requesters, each with a valid/ready request interface.
- Grants at most one access per cycle, round-robin, and never asserts ren and wen together.
- Tags read responses with the requester ID and returns them in order through a small response FIFO with valid/ready flow control.
- Sits between the compute-unit address generators and the SRAM instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, data width; must match the SRAM WIDTH
DEPTH, 32, SRAM depth; AW = $clog2(DEPTH)
RSP_DEPTH, 2, response FIFO entries (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  request pending, one bit per requester
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  N_REQ*WIDTH  packed write data
req_ready  out  N_REQ  one-hot grant; handshake completes in a cycle with valid & ready
rsp_valid  out  1  head of response FIFO valid
rsp_ready  in  1  consumer accepts the response
rsp_id  out  $clog2(N_REQ)  requester that issued the read
rsp_data  out  WIDTH  read data
sram_addr  out  AW  to SRAM addr
sram_ren  out  1  to SRAM ren
sram_wen  out  1  to SRAM wen
sram_d  out  WIDTH  to SRAM d
sram_q  in  WIDTH  from SRAM q

Behaviour:
- Reset: clk and rst are shared with the SRAM. rst (synchronous, active-high) sets rr_ptr=0, inflight=0 and FIFO count=0. Consequently req_ready=0, sram_ren=0, sram_wen=0 and rsp_valid=0 while rst is high.
- Credit: rd_ok = (fifo_count + inflight - (rsp_valid & rsp_ready)) < RSP_DEPTH. This is a combinational path from rsp_ready to sram_ren, which is accepted.
- Eligibility: eligible[i] = req_valid[i] & (req_we[i] | rd_ok). A blocked read never blocks another requester's write.
- Arbitration (combinational):
  - Scan eligible requesters starting at rr_ptr, modulo N_REQ; the first hit is granted.
  - req_ready = one-hot of the grant, or 0 if none.
  - No request is stored inside the arbiter; a requester holds valid until it sees ready.
- rr_ptr: updates only on a grant, to (g+1) mod N_REQ. It holds when there is no grant.
- SRAM drive (same cycle as the grant):
  - sram_addr = addr[g]; sram_d = wdata[g].
  - sram_wen = granted & we[g]; sram_ren = granted & !we[g].
  - With no grant, both strobes are 0, and addr/d are 0 (don't care).
- Read pipeline:
  - A read granted in cycle t sets inflight=1 and inflight_id=g for cycle t+1.
  - In t+1, sram_q holds the data; it is pushed with inflight_id into the FIFO at the end of t+1.
  - Earliest rsp_valid is t+2, so read-to-response latency is 2 cycles with an empty FIFO.
  - Sustained one read per cycle is possible with RSP_DEPTH=2 while rsp_ready=1.
- FIFO:
  - Push and pop may occur in the same cycle.
  - Full: reads are stalled by the credit rule, so a push never overflows. Overflow is an assertion error.
  - Empty: rsp_valid=0, and rsp_id/rsp_data are don't care.
  - rsp_id/rsp_data stay stable while rsp_valid & !rsp_ready.
- Ordering: a write granted at t followed by a read of the same address granted at t+1 or later returns the new data, because the SRAM write completes during t+1.
- Simultaneous events:
  - A read and a write in the same cycle from different requesters are serialised by round-robin, one per cycle.
  - ren & wen is never driven together; this is asserted.
- Reset mid-operation: any inflight read is dropped and the FIFO is flushed, with no response emitted. Requesters must re-issue.

Decomposition:
- Package sram_arb_pkg: IDW = $clog2(N_REQ) helper, plus RD/WR encoding constants for req_we.
- Sub-module rr_pick: combinational round-robin one-hot picker (inputs eligible, ptr; outputs grant one-hot, grant index, any).
- The response FIFO stays inline: a small register array with read/write pointers and a count.

Test Plan:
- Requester 1 writes 0xDEAD_BEEF to addr 5 in cycle t; requester 1 reads addr 5 in t+1 -> sram_wen only in t, sram_ren only in t+1, rsp_valid at t+3 with rsp_id=1 and rsp_data=0xDEADBEEF.
- All 4 requesters hold valid for reads to addrs 0..3 (preloaded 10,11,12,13), rsp_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; responses (0,10),(1,11),(2,12),(3,13) on consecutive cycles.
- rsp_ready=0 while requester 0 streams reads -> exactly 2 reads accepted, then req_ready[0]=0. Requester 2 writes are still granted meanwhile. Raising rsp_ready drains 2 responses and reads resume.
- Random mix of reads and writes from all requesters for 10k cycles against a scoreboard memory model -> sram_ren & sram_wen never both 1; every read returns the model value with the correct id; no requester waits more than N_REQ cycles when rd_ok=1.
- rst asserted one cycle after a read grant, with 1 entry already in the FIFO -> rsp_valid=0 the cycle after rst; no stale response appears after rst deasserts; rr_ptr restarts at 0.
- Single requester 3 valid with ptr=0 -> granted immediately; ptr becomes 0 (wrap from 3).
